// File: rtl/reg_bank_wb.sv
// Write-back register bank: a small in-order write queue in front of a
// 32-entry register array whose contents are exposed in parallel on a flat bus
// for the register read multiplexer. Register 0 always reads zero, and the
// pending-write query reports writes that are queued but not yet committed.
module reg_bank_wb #(
    parameter int WIDTH  = 32,
    parameter int QDEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid_i,
    output logic                  wb_ready_o,
    input  logic [4:0]            wb_addr_i,
    input  logic [WIDTH-1:0]      wb_data_i,
    input  logic                  commit_en_i,
    input  logic [4:0]            rd_addr_i,
    output logic                  rd_pending_o,
    output logic                  q_empty_o,
    output logic [32*WIDTH-1:0]   regs_flat_o
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [4:0]       addr;
        logic [WIDTH-1:0] data;
    } wb_entry_t;

    wb_entry_t        q_mem_q [QDEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] regs_q [1:31];

    logic      accept;
    logic      commit;
    wb_entry_t head_entry;

    assign wb_ready_o = rst_n && (count_q != CW'(QDEPTH));
    assign q_empty_o  = (count_q == '0);
    assign accept     = wb_valid_i && wb_ready_o;
    assign commit     = commit_en_i && (count_q != '0);
    assign head_entry = q_mem_q[head_q];

    // Next-state for queue pointers and occupancy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (accept) tail_d = tail_q + PW'(1);
        if (commit) head_d = head_q + PW'(1);
        case ({accept, commit})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage: write the accepted entry at the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: queue storage is deliberately not reset; slots are only ever read once count marks them occupied.
        if (accept) q_mem_q[tail_q] <= '{addr: wb_addr_i, data: wb_data_i};
    end

    // Register array: cleared on reset, written by the head entry on commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (commit && (head_entry.addr == 5'(i))) regs_q[i] <= head_entry.data;
            end
        end
    end

    // Hazard query: any occupied slot targeting rd_addr (x0 never pending).
    always_comb begin
        rd_pending_o = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if ((i < int'(count_q)) && (q_mem_q[head_q + PW'(i)].addr == rd_addr_i))
                rd_pending_o = 1'b1;
        end
        if (rd_addr_i == 5'd0) rd_pending_o = 1'b0;
    end

    // Flat read bus straight from the array flops; slot 0 is tied to zero.
    for (genvar g = 0; g < 32; g++) begin : g_flat
        if (g == 0) begin : g_zero
            assign regs_flat_o[WIDTH-1:0] = '0;
        end else begin : g_reg
            assign regs_flat_o[g*WIDTH +: WIDTH] = regs_q[g];
        end
    end

endmodule

// File: tb/tb_reg_bank_wb.sv
// Self-checking bench for reg_bank_wb: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// queue-based behavioural model.
module tb_reg_bank_wb;

    localparam int WIDTH  = 32;
    localparam int QDEPTH = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                wb_valid = 1'b0;
    logic                wb_ready;
    logic [4:0]          wb_addr = '0;
    logic [WIDTH-1:0]    wb_data = '0;
    logic                commit_en = 1'b0;
    logic [4:0]          rd_addr = '0;
    logic                rd_pending;
    logic                q_empty;
    logic [32*WIDTH-1:0] regs_flat;

    int n_checks = 0;
    int n_errors = 0;

    reg_bank_wb #(.WIDTH(WIDTH), .QDEPTH(QDEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid_i   (wb_valid),
        .wb_ready_o   (wb_ready),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .commit_en_i  (commit_en),
        .rd_addr_i    (rd_addr),
        .rd_pending_o (rd_pending),
        .q_empty_o    (q_empty),
        .regs_flat_o  (regs_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32*WIDTH-1:0] act,
                         input logic [32*WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] reg_of(input int i);
        return regs_flat[i*WIDTH +: WIDTH];
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]       a;
        logic [WIDTH-1:0] d;
    } ent_t;

    logic [WIDTH-1:0] m_regs [32];
    ent_t             m_q [$];
    bit               model_on = 0;

    initial for (int i = 0; i < 32; i++) m_regs[i] = '0;

    // Model advances on each rising edge using the inputs present at that edge.
    always @(posedge clk) begin
        bit   acc;
        ent_t e;
        if (!rst_n) begin
            m_q.delete();
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            model_on = 1;
        end else begin
            acc = wb_valid && (m_q.size() < QDEPTH);
            if (commit_en && m_q.size() > 0) begin
                e = m_q.pop_front();
                if (e.a != 0) m_regs[e.a] = e.d;
            end
            if (acc) m_q.push_back('{a: wb_addr, d: wb_data});
        end
    end

    // Compare process: all outputs against the model, mid-cycle.
    always @(negedge clk) begin
        logic [32*WIDTH-1:0] exp_flat;
        bit                  exp_pend;
        if (model_on) begin
            for (int i = 0; i < 32; i++) exp_flat[i*WIDTH +: WIDTH] = m_regs[i];
            exp_pend = 0;
            foreach (m_q[k]) if (m_q[k].a == rd_addr && rd_addr != 0) exp_pend = 1;
            check("model wb_ready", wb_ready, rst_n && (m_q.size() < QDEPTH));
            check("model q_empty", q_empty, m_q.size() == 0);
            check("model rd_pending", rd_pending, exp_pend);
            check("model regs_flat", regs_flat, exp_flat);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 32; i++) check(name, reg_of(i), '0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        // Reset, then idle.
        cyc();
        cyc();
        #1;
        check("reset wb_ready low", wb_ready, 1'b0);
        check("reset q_empty", q_empty, 1'b1);
        check("reset regs_flat", regs_flat, '0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("post-reset wb_ready", wb_ready, 1'b1);
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            #0.1;
            check("idle rd_pending", rd_pending, 1'b0);
        end

        // Single write with commit enabled.
        commit_en = 1'b1;
        rd_addr   = 5'd5;
        wb_valid  = 1'b1;
        wb_addr   = 5'd5;
        wb_data   = 32'hDEADBEEF;
        #1;
        check("single pending before accept", rd_pending, 1'b0);
        cyc();                                  // edge N: accepted
        wb_valid = 1'b0;
        #1;
        check("single pending after accept", rd_pending, 1'b1);
        check("single reg5 not yet", reg_of(5), '0);
        cyc();                                  // edge N+1: committed
        check("single reg5", reg_of(5), 32'hDEADBEEF);
        check("single pending cleared", rd_pending, 1'b0);
        for (int i = 0; i < 32; i++)
            if (i != 5) check("single others", reg_of(i), '0);

        // Write to x0, held in the queue first.
        commit_en = 1'b0;
        rd_addr   = 5'd0;
        wb_valid  = 1'b1;
        wb_addr   = 5'd0;
        wb_data   = 32'hFFFFFFFF;
        cyc();
        wb_valid = 1'b0;
        #1;
        check("x0 queued", q_empty, 1'b0);
        check("x0 never pending", rd_pending, 1'b0);
        commit_en = 1'b1;
        cyc();
        check("x0 dequeued", q_empty, 1'b1);
        check("x0 stays zero", reg_of(0), '0);

        // Full queue and backpressure.
        commit_en = 1'b0;
        wb_valid  = 1'b1;
        wb_addr   = 5'd3;
        wb_data   = 32'h11;
        cyc();
        wb_addr = 5'd4;
        wb_data = 32'h22;
        cyc();
        wb_addr = 5'd7;
        wb_data = 32'h33;
        rd_addr = 5'd7;
        #1;
        check("full wb_ready", wb_ready, 1'b0);
        cyc();
        check("full still held", wb_ready, 1'b0);
        check("held write not pending", rd_pending, 1'b0);
        rd_addr = 5'd4;
        #1;
        check("queued reg4 pending", rd_pending, 1'b1);
        commit_en = 1'b1;
        rd_addr   = 5'd7;
        cyc();
        check("bp reg3", reg_of(3), 32'h11);
        check("bp reg4 not yet", reg_of(4), '0);
        check("bp ready after commit", wb_ready, 1'b1);
        cyc();                                  // reg4 commits, write 7 accepted
        wb_valid = 1'b0;
        #1;
        check("bp reg4", reg_of(4), 32'h22);
        check("bp reg7 pending", rd_pending, 1'b1);
        cyc();
        check("bp reg7", reg_of(7), 32'h33);
        check("bp drained", q_empty, 1'b1);

        // Same address back-to-back.
        wb_valid = 1'b1;
        wb_addr  = 5'd9;
        wb_data  = 32'hA;
        cyc();
        wb_data = 32'hB;
        cyc();
        wb_valid = 1'b0;
        check("waw reg9 first", reg_of(9), 32'hA);
        cyc();
        check("waw reg9 final", reg_of(9), 32'hB);

        // Reset mid-operation with two entries queued.
        commit_en = 1'b0;
        wb_valid  = 1'b1;
        wb_addr   = 5'd10;
        wb_data   = 32'h55;
        cyc();
        wb_addr = 5'd11;
        wb_data = 32'h66;
        cyc();
        wb_valid = 1'b0;
        rst_n    = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        check("midreset q_empty", q_empty, 1'b1);
        check_all_zero("midreset regs");
        commit_en = 1'b1;
        rd_addr   = 5'd10;
        #1;
        check("midreset not pending", rd_pending, 1'b0);
        cyc();
        cyc();
        check_all_zero("midreset no late commit");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 249) != 0);
            wb_valid  = ($urandom_range(0, 2) != 0);
            wb_addr   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7))
                                                    : 5'($urandom_range(0, 31));
            wb_data   = $urandom;
            commit_en = ($urandom_range(0, 2) != 0);
            rd_addr   = 5'($urandom_range(0, 7));
            cyc();
        end
        rst_n    = 1'b1;
        wb_valid = 1'b0;
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
